// File: rtl/note_pkg.sv
// Shared types, lane geometry defaults and the lane-to-X helper for the
// falling-note scheduler and its hit arbiter.
package note_pkg;

    typedef enum logic [2:0] {
        LANE_RED    = 3'd0,
        LANE_BLUE   = 3'd1,
        LANE_GREEN  = 3'd2,
        LANE_YELLOW = 3'd3,
        LANE_ORANGE = 3'd4
    } lane_t;

    typedef struct packed {
        logic       valid;
        lane_t      lane;
        logic [9:0] y;
    } note_slot_t;

    typedef enum logic {
        ST_IDLE,
        ST_UPDATE
    } sched_state_t;

    localparam int NUM_LANES       = 5;
    localparam int DEF_NUM_SLOTS   = 8;
    localparam int DEF_SPEED       = 4;
    localparam int DEF_SCREEN_H    = 480;
    localparam int DEF_SPRITE_W    = 64;
    localparam int DEF_LANE_X0     = 128;
    localparam int DEF_LANE_PITCH  = 80;

    // Left edge of a lane's sprite column; notes carry no X of their own.
    function automatic logic [11:0] laneX(input lane_t lane, input int x0, input int pitch);
        return 12'(x0 + int'(lane) * pitch);
    endfunction

endpackage

// File: rtl/note_scheduler_if.sv
// Spawn handshake, pixel query and status bundle between the song sequencer /
// video pipeline (master) and the note scheduler (slave).
interface note_scheduler_if;

    logic        frame_start;
    logic        spawn_valid;
    logic [2:0]  spawn_lane;
    logic        spawn_ready;
    logic        spawn_err;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic        is_sprite_red;
    logic        is_sprite_blue;
    logic        is_sprite_green;
    logic        is_sprite_yellow;
    logic        is_sprite_orange;
    logic [12:0] sprite_addr;
    logic [4:0]  active_count;
    logic [7:0]  miss_count;
    logic        frame_overrun;

    modport master (
        output frame_start, spawn_valid, spawn_lane, DrawX, DrawY,
        input  spawn_ready, spawn_err, is_sprite_red, is_sprite_blue,
               is_sprite_green, is_sprite_yellow, is_sprite_orange,
               sprite_addr, active_count, miss_count, frame_overrun
    );

    modport slave (
        input  frame_start, spawn_valid, spawn_lane, DrawX, DrawY,
        output spawn_ready, spawn_err, is_sprite_red, is_sprite_blue,
               is_sprite_green, is_sprite_yellow, is_sprite_orange,
               sprite_addr, active_count, miss_count, frame_overrun
    );

endinterface

// File: rtl/note_hit_arbiter.sv
// Combinational per-slot sprite window test with lowest-index priority,
// yielding the winning lane and its sprite-local ROM address.
module note_hit_arbiter
    import note_pkg::*;
#(
    parameter int NUM_SLOTS  = DEF_NUM_SLOTS,
    parameter int SPRITE_W   = DEF_SPRITE_W,
    parameter int LANE_X0    = DEF_LANE_X0,
    parameter int LANE_PITCH = DEF_LANE_PITCH
) (
    input  note_slot_t [NUM_SLOTS-1:0] slots_i,
    input  logic [9:0]                 drawX_i,
    input  logic [9:0]                 drawY_i,
    output logic                       hit_o,
    output lane_t                      lane_o,
    output logic [12:0]                addr_o
);

    logic [11:0] px;
    logic [11:0] py;

    assign px = {2'b00, drawX_i};
    assign py = {2'b00, drawY_i};

    // Scan from the top index downward so the lowest-index hit is the one left standing.
    always_comb begin
        logic [11:0] sx;
        logic [11:0] sy;
        hit_o  = 1'b0;
        lane_o = LANE_RED;
        addr_o = '0;
        sx     = '0;
        sy     = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            sx = laneX(slots_i[i].lane, LANE_X0, LANE_PITCH);
            sy = {2'b00, slots_i[i].y};
            if (slots_i[i].valid &&
                px >= sx && px < sx + 12'(SPRITE_W) &&
                py >= sy && py < sy + 12'(SPRITE_W)) begin
                hit_o  = 1'b1;
                lane_o = slots_i[i].lane;
                addr_o = 13'(py - sy) * 13'(SPRITE_W) + 13'(px - sx);
            end
        end
    end

endmodule

// File: rtl/note_scheduler.sv
// Falling-note pool: accepts spawns while idle, advances every note once per
// frame during vblank, and answers per-pixel sprite queries one cycle later.
module note_scheduler
    import note_pkg::*;
#(
    parameter int NUM_SLOTS  = DEF_NUM_SLOTS,
    parameter int SPEED      = DEF_SPEED,
    parameter int SCREEN_H   = DEF_SCREEN_H,
    parameter int SPRITE_W   = DEF_SPRITE_W,
    parameter int LANE_X0    = DEF_LANE_X0,
    parameter int LANE_PITCH = DEF_LANE_PITCH
) (
    input logic            Clk,
    input logic            Reset,
    note_scheduler_if.slave bus
);

    localparam int IDX_W = $clog2(NUM_SLOTS);

    sched_state_t               state_q, state_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    note_slot_t [NUM_SLOTS-1:0] slots_q, slots_d;
    logic [4:0]                 activeCount_q, activeCount_d;
    logic [7:0]                 missCount_q, missCount_d;
    logic                       spawnErr_q, spawnErr_d;
    logic                       overrun_q, overrun_d;
    logic [4:0]                 sprite_q, sprite_d;
    logic [12:0]                addr_q, addr_d;

    logic             freeFound;
    logic [IDX_W-1:0] freeIdx;
    logic             spawnReady;
    logic [10:0]      nextY;
    logic             hit;
    lane_t            hitLane;
    logic [12:0]      hitAddr;

    always_comb begin
        freeFound = 1'b0;
        freeIdx   = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!slots_q[i].valid) begin
                freeFound = 1'b1;
                freeIdx   = IDX_W'(i);
            end
        end
    end

    assign spawnReady = !Reset && (state_q == ST_IDLE) && freeFound && !bus.frame_start;
    assign nextY      = {1'b0, slots_q[idx_q].y} + 11'(SPEED);

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        slots_d       = slots_q;
        activeCount_d = activeCount_q;
        missCount_d   = missCount_q;
        spawnErr_d    = 1'b0;
        overrun_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.spawn_valid && spawnReady) begin
                    if (bus.spawn_lane >= 3'(NUM_LANES)) begin
                        spawnErr_d = 1'b1;
                    end else begin
                        slots_d[freeIdx] = '{valid: 1'b1, lane: lane_t'(bus.spawn_lane), y: 10'd0};
                        activeCount_d    = activeCount_q + 5'd1;
                    end
                end
                if (bus.frame_start) begin
                    state_d = ST_UPDATE;
                    idx_d   = '0;
                end
            end
            ST_UPDATE: begin
                overrun_d = bus.frame_start;
                if (slots_q[idx_q].valid) begin
                    if (nextY >= 11'(SCREEN_H)) begin
                        slots_d[idx_q].valid = 1'b0;
                        activeCount_d        = activeCount_q - 5'd1;
                        if (missCount_q != 8'hFF) begin
                            missCount_d = missCount_q + 8'd1;
                        end
                    end else begin
                        slots_d[idx_q].y = nextY[9:0];
                    end
                end
                if (idx_q == IDX_W'(NUM_SLOTS - 1)) begin
                    state_d = ST_IDLE;
                end
                idx_d = idx_q + 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    note_hit_arbiter #(
        .NUM_SLOTS (NUM_SLOTS),
        .SPRITE_W  (SPRITE_W),
        .LANE_X0   (LANE_X0),
        .LANE_PITCH(LANE_PITCH)
    ) u_arbiter (
        .slots_i (slots_q),
        .drawX_i (bus.DrawX),
        .drawY_i (bus.DrawY),
        .hit_o   (hit),
        .lane_o  (hitLane),
        .addr_o  (hitAddr)
    );

    // Registering here lines the flags up with the frameRAM's one-cycle read.
    assign sprite_d = hit ? (5'b00001 << hitLane) : 5'b00000;
    assign addr_d   = hit ? hitAddr : 13'd0;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            slots_q       <= '0;
            activeCount_q <= '0;
            missCount_q   <= '0;
            spawnErr_q    <= 1'b0;
            overrun_q     <= 1'b0;
            sprite_q      <= '0;
            addr_q        <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            slots_q       <= slots_d;
            activeCount_q <= activeCount_d;
            missCount_q   <= missCount_d;
            spawnErr_q    <= spawnErr_d;
            overrun_q     <= overrun_d;
            sprite_q      <= sprite_d;
            addr_q        <= addr_d;
        end
    end

    assign bus.spawn_ready      = spawnReady;
    assign bus.spawn_err        = spawnErr_q;
    assign bus.frame_overrun    = overrun_q;
    assign bus.active_count     = activeCount_q;
    assign bus.miss_count       = missCount_q;
    assign bus.is_sprite_red    = sprite_q[0];
    assign bus.is_sprite_blue   = sprite_q[1];
    assign bus.is_sprite_green  = sprite_q[2];
    assign bus.is_sprite_yellow = sprite_q[3];
    assign bus.is_sprite_orange = sprite_q[4];
    assign bus.sprite_addr      = addr_q;

endmodule

// File: tb/tb_note_scheduler.sv
// Randomized scoreboard bench for note_scheduler: a frame-level note model
// queues the expected outputs each cycle and a monitor compares them.
module tb_note_scheduler;
    import note_pkg::*;

    localparam int NSLOTS   = 8;
    localparam int SPEED    = 4;
    localparam int SCREEN_H = 480;
    localparam int SPRITE_W = 64;
    localparam int X0       = 128;
    localparam int PITCH    = 80;

    logic Clk   = 1'b0;
    logic Reset = 1'b1;

    note_scheduler_if ifc();

    note_scheduler #(
        .NUM_SLOTS (NSLOTS),
        .SPEED     (SPEED),
        .SCREEN_H  (SCREEN_H),
        .SPRITE_W  (SPRITE_W),
        .LANE_X0   (X0),
        .LANE_PITCH(PITCH)
    ) dut (
        .Clk  (Clk),
        .Reset(Reset),
        .bus  (ifc.slave)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        bit checkState;
        bit checkPix;
        bit ready;
        bit err;
        bit ovr;
        int active;
        int miss;
        int spr;
        int addr;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;

    // Note pool as the song sees it: whole frames applied at once.
    bit mValid[NSLOTS];
    int mLane[NSLOTS];
    int mY[NSLOTS];
    int mMiss;
    int mBusy;
    bit pendPixOk;
    int pendSpr;
    int pendAddr;
    bit pendErr;
    bit pendOvr;

    task automatic checkOutput(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    function automatic int countNotes();
        int n = 0;
        for (int i = 0; i < NSLOTS; i++) if (mValid[i]) n++;
        return n;
    endfunction

    function automatic int firstFree();
        for (int i = 0; i < NSLOTS; i++) if (!mValid[i]) return i;
        return -1;
    endfunction

    task automatic modelPixel(input int dx, input int dy, output int spr, output int addr);
        bit found = 0;
        spr  = 0;
        addr = 0;
        for (int i = 0; i < NSLOTS; i++) begin
            int x = X0 + mLane[i] * PITCH;
            if (!found && mValid[i] && dx >= x && dx < x + SPRITE_W && dy >= mY[i] && dy < mY[i] + SPRITE_W) begin
                found = 1;
                spr   = 1 << mLane[i];
                addr  = (dy - mY[i]) * SPRITE_W + (dx - x);
            end
        end
    endtask

    task automatic applyFrame();
        for (int i = 0; i < NSLOTS; i++) begin
            if (mValid[i]) begin
                if (mY[i] + SPEED >= SCREEN_H) begin
                    mValid[i] = 0;
                    if (mMiss < 255) mMiss++;
                end else begin
                    mY[i] += SPEED;
                end
            end
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < NSLOTS; i++) begin
            mValid[i] = 0;
            mLane[i]  = 0;
            mY[i]     = 0;
        end
        mMiss = 0; mBusy = 0;
        pendPixOk = 1; pendSpr = 0; pendAddr = 0; pendErr = 0; pendOvr = 0;
    endtask

    // Mostly aim the beam at or just around a live note so hits and edges get exercised.
    task automatic pickPixel(output int dx, output int dy);
        int n = countNotes();
        dx = $urandom_range(0, 639);
        dy = $urandom_range(0, 479);
        if (n > 0 && $urandom_range(0, 9) < 7) begin
            int k = $urandom_range(0, NSLOTS - 1);
            while (!mValid[k]) k = (k + 1) % NSLOTS;
            dx = X0 + mLane[k] * PITCH + $urandom_range(0, SPRITE_W + 5) - 3;
            dy = mY[k] + $urandom_range(0, SPRITE_W + 5) - 3;
            if (dx < 0) dx = 0;
            if (dy < 0) dy = 0;
            if (dx > 1023) dx = 1023;
            if (dy > 1023) dy = 1023;
        end
    endtask

    task automatic resetCycle();
        exp_t e;
        Reset = 1'b1;
        ifc.frame_start = 1'b0;
        ifc.spawn_valid = 1'b0;
        ifc.spawn_lane  = 3'd0;
        e = '{checkState: 1, checkPix: 1, ready: 0, err: 0, ovr: 0, active: 0, miss: 0, spr: 0, addr: 0};
        expQ.push_back(e);
        modelReset();
        @(posedge Clk); #1;
    endtask

    task automatic applyStimulus(input bit fs, input bit sv, input int sl, input int dx, input int dy,
                                 output bit accepted);
        exp_t e;
        int   freeSlot;
        bit   rdy;
        int   spr;
        int   addr;
        Reset = 1'b0;
        ifc.frame_start = fs;
        ifc.spawn_valid = sv;
        ifc.spawn_lane  = 3'(sl);
        ifc.DrawX       = 10'(dx);
        ifc.DrawY       = 10'(dy);
        freeSlot = firstFree();
        rdy = (mBusy == 0) && (freeSlot >= 0) && !fs;
        e.ready      = rdy;
        e.checkState = (mBusy == 0);
        e.active     = countNotes();
        e.miss       = mMiss;
        e.err        = pendErr;
        e.ovr        = pendOvr;
        e.checkPix   = pendPixOk;
        e.spr        = pendSpr;
        e.addr       = pendAddr;
        expQ.push_back(e);
        modelPixel(dx, dy, spr, addr);
        pendPixOk = (mBusy == 0);
        pendSpr   = spr;
        pendAddr  = addr;
        pendErr   = 0;
        pendOvr   = 0;
        accepted  = sv && rdy;
        if (accepted) begin
            if (sl > 4) pendErr = 1;
            else begin
                mValid[freeSlot] = 1;
                mLane[freeSlot]  = sl;
                mY[freeSlot]     = 0;
            end
        end
        if (mBusy > 0) begin
            pendOvr = fs;
            mBusy--;
            if (mBusy == 0) applyFrame();
        end else if (fs) begin
            mBusy = NSLOTS;
        end
        @(posedge Clk); #1;
    endtask

    // Monitor: pops one expectation per cycle and compares against what the DUT shows.
    initial begin
        exp_t e;
        int   actSpr;
        forever begin
            @(negedge Clk);
            while (expQ.size() > 0) begin
                e = expQ.pop_front();
                actSpr = int'({ifc.is_sprite_orange, ifc.is_sprite_yellow, ifc.is_sprite_green,
                               ifc.is_sprite_blue, ifc.is_sprite_red});
                checkOutput("spawn_ready", int'(ifc.spawn_ready), int'(e.ready));
                checkOutput("spawn_err", int'(ifc.spawn_err), int'(e.err));
                checkOutput("frame_overrun", int'(ifc.frame_overrun), int'(e.ovr));
                if (e.checkState) begin
                    checkOutput("active_count", int'(ifc.active_count), e.active);
                    checkOutput("miss_count", int'(ifc.miss_count), e.miss);
                end
                if (e.checkPix) begin
                    checkOutput("is_sprite", actSpr, e.spr);
                    checkOutput("sprite_addr", int'(ifc.sprite_addr), e.addr);
                end
            end
        end
    end

    initial begin
        bit pend = 0;
        int pendLane = 0;
        bit acc;
        int dx;
        int dy;
        ifc.frame_start = 1'b0;
        ifc.spawn_valid = 1'b0;
        ifc.spawn_lane  = 3'd0;
        ifc.DrawX       = 10'd0;
        ifc.DrawY       = 10'd0;
        modelReset();
        @(posedge Clk); #1;
        resetCycle();
        resetCycle();

        // Mixed traffic: held spawn requests, bad lanes, frame pulses that may land mid-update.
        for (int c = 0; c < 4000; c++) begin
            if (!pend && $urandom_range(0, 3) == 0) begin
                pend = 1;
                pendLane = ($urandom_range(0, 9) == 0) ? $urandom_range(5, 7) : $urandom_range(0, 4);
            end
            pickPixel(dx, dy);
            applyStimulus($urandom_range(0, 11) == 0, pend, pendLane, dx, dy, acc);
            if (acc) pend = 0;
        end

        // Steady frames with the pool kept full, long enough to push miss_count into saturation.
        for (int c = 0; c < 45000; c++) begin
            if (!pend) begin
                pend = 1;
                pendLane = $urandom_range(0, 4);
            end
            pickPixel(dx, dy);
            applyStimulus((c % 10) == 0, pend, pendLane, dx, dy, acc);
            if (acc) pend = 0;
        end
        checkOutput("miss_saturated_model", mMiss, 255);

        // Reset lands on the fourth update cycle of a busy frame.
        pickPixel(dx, dy);
        applyStimulus(1'b1, 1'b0, 0, dx, dy, acc);
        for (int c = 0; c < 3; c++) begin
            pickPixel(dx, dy);
            applyStimulus(1'b0, 1'b0, 0, dx, dy, acc);
        end
        resetCycle();
        resetCycle();
        pend = 0;
        for (int c = 0; c < 200; c++) begin
            if (!pend && $urandom_range(0, 3) == 0) begin
                pend = 1;
                pendLane = $urandom_range(0, 6);
            end
            dx = $urandom_range(100, 560);
            dy = $urandom_range(0, 120);
            applyStimulus($urandom_range(0, 9) == 0, pend, pendLane, dx, dy, acc);
            if (acc) pend = 0;
        end

        repeat (2) @(negedge Clk);
        checkOutput("queue_drained", expQ.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
